sobel_window_engine: RTL and testbench



---
 rtl/sobel_window_engine_pkg.sv | 26 ++
 rtl/sobel_window_engine_if.sv | 24 ++
 rtl/sobel_window_engine_kernel_1d.sv | 33 +++
 rtl/sobel_window_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_sobel_window_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_window_engine_pkg.sv
// Shared types, widths and helpers for the Sobel window engine.
// Optional feature macro: SOBEL_THRESHOLD_EN (binary edge map instead of magnitude).
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int WIN_W  = 72;
    localparam int DIM_W  = 11;
    localparam int GRAD_W = 11;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic [DIM_W-1:0]         dim_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [GRAD_W-1:0]        mag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } engine_state_t;

    // Byte k of the window sits at column k/3, row k%3.
    function automatic pix_t win_px(input logic [WIN_W-1:0] window, input int c, input int r);
        return window[8*(3*c + r) +: 8];
    endfunction

endpackage

// File: rtl/sobel_window_engine_if.sv
// Window-in / pixel-out stream bundle between the line buffer, the engine and the writer.
// Optional feature macro: SOBEL_THRESHOLD_EN (does not change this interface).
interface sobel_window_engine_if;
    import sobel_pkg::*;

    logic [WIN_W-1:0] window_in;
    logic             valid_in;
    pix_t             pixel_out;
    logic             valid_out;
    logic             sol;
    logic             eol;
    logic             eof;

    modport master (
        output window_in, valid_in,
        input  pixel_out, valid_out, sol, eol, eof
    );

    modport slave (
        input  window_in, valid_in,
        output pixel_out, valid_out, sol, eol, eof
    );

endinterface

// File: rtl/sobel_window_engine_kernel_1d.sv
// One Sobel gradient: (a + 2b + c) - (d + 2e + f), registered once.
// Optional feature macro: SOBEL_THRESHOLD_EN (not used here).
module sobel_kernel_1d
    import sobel_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  pix_t  a,
    input  pix_t  b,
    input  pix_t  c,
    input  pix_t  d,
    input  pix_t  e,
    input  pix_t  f,
    output grad_t grad
);

    logic [GRAD_W-1:0] pos_sum;
    logic [GRAD_W-1:0] neg_sum;

    // Each weighted sum peaks at 1020, so the 11-bit difference never overflows.
    assign pos_sum = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    assign neg_sum = {3'b000, d} + {2'b00, e, 1'b0} + {3'b000, f};

    // Pipeline stage 1 register for the gradient.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grad <= '0;
        end else begin
            grad <= grad_t'(pos_sum - neg_sum);
        end
    end

endmodule

// File: rtl/sobel_window_engine.sv
// Sobel edge-magnitude engine: 3-stage pipeline with raster position tagging and frame control.
// Optional feature macro: SOBEL_THRESHOLD_EN (output 255/0 by comparing magnitude to threshold).
module sobel_window_engine
    import sobel_pkg::*;
#(
    parameter int MAX_WIDTH  = 1920,
    parameter int MAX_HEIGHT = 1080
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  dim_t                  image_width,
    input  dim_t                  image_height,
    input  pix_t                  threshold,
    sobel_window_engine_if.slave  win,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  drop_err,
    output logic                  cfg_err
);

    localparam dim_t MAX_W = dim_t'(MAX_WIDTH);
    localparam dim_t MAX_H = dim_t'(MAX_HEIGHT);

    engine_state_t state;
    engine_state_t state_next;

    dim_t w_reg;
    dim_t h_reg;
    dim_t col;
    dim_t row;

    logic cfg_ok;
    logic start;
    logic accept;
    logic tag_sol;
    logic tag_eol;
    logic tag_eof;

    grad_t gx1;
    grad_t gy1;
    logic  v1, sol1, eol1, eof1;
    logic  v2, sol2, eol2, eof2;

    mag_t abs_x;
    mag_t abs_y;
    mag_t mag_sum;

    pix_t pixel_r;
    logic valid_r, sol_r, eol_r, eof_r;

    assign cfg_ok  = (image_width != '0) && (image_height != '0) &&
                     (image_width <= MAX_W) && (image_height <= MAX_H);
    assign start   = (state == IDLE) && enable && cfg_ok;
    assign accept  = (state == RUN) && win.valid_in;
    assign tag_sol = (col == '0);
    assign tag_eol = (col == w_reg - dim_t'(1));
    assign tag_eof = tag_eol && (row == h_reg - dim_t'(1));
    assign busy    = (state == RUN) || (state == DRAIN);

    // Frame sequencing: leave DRAIN one cycle after the eof pixel is presented.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && tag_eof) state_next = DRAIN;
            DRAIN:   if (frame_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame dimensions and raster position of the next accepted window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_reg <= '0;
            h_reg <= '0;
            col   <= '0;
            row   <= '0;
        end else if (start) begin
            w_reg <= image_width;
            h_reg <= image_height;
            col   <= '0;
            row   <= '0;
        end else if (accept) begin
            if (tag_eol) begin
                col <= '0;
                row <= row + dim_t'(1);
            end else begin
                col <= col + dim_t'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_err <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (win.valid_in && (state != RUN)) drop_err <= 1'b1;
            if ((state == IDLE) && enable && !cfg_ok) cfg_err <= 1'b1;
        end
    end

    sobel_kernel_1d u_kernel_gx (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (win_px(win.window_in, 2, 0)),
        .b       (win_px(win.window_in, 2, 1)),
        .c       (win_px(win.window_in, 2, 2)),
        .d       (win_px(win.window_in, 0, 0)),
        .e       (win_px(win.window_in, 0, 1)),
        .f       (win_px(win.window_in, 0, 2)),
        .grad    (gx1)
    );

    sobel_kernel_1d u_kernel_gy (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (win_px(win.window_in, 0, 2)),
        .b       (win_px(win.window_in, 1, 2)),
        .c       (win_px(win.window_in, 2, 2)),
        .d       (win_px(win.window_in, 0, 0)),
        .e       (win_px(win.window_in, 1, 0)),
        .f       (win_px(win.window_in, 2, 0)),
        .grad    (gy1)
    );

    // Stage 1 valid and position tags, aligned with the kernel registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            sol1 <= 1'b0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
        end else begin
            v1   <= accept;
            sol1 <= accept && tag_sol;
            eol1 <= accept && tag_eol;
            eof1 <= accept && tag_eof;
        end
    end

    assign abs_x   = gx1[GRAD_W-1] ? mag_t'(-gx1) : mag_t'(gx1);
    assign abs_y   = gy1[GRAD_W-1] ? mag_t'(-gy1) : mag_t'(gy1);
    assign mag_sum = abs_x + abs_y;

    // Stage 2 valid and tags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v2   <= 1'b0;
            sol2 <= 1'b0;
            eol2 <= 1'b0;
            eof2 <= 1'b0;
        end else begin
            v2   <= v1;
            sol2 <= sol1;
            eol2 <= eol1;
            eof2 <= eof1;
        end
    end

`ifdef SOBEL_THRESHOLD_EN
    logic edge2;

    // Stage 2 compares the magnitude against the threshold sampled this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge2 <= 1'b0;
        end else begin
            edge2 <= (mag_sum > {3'b000, threshold});
        end
    end

    // Stage 3 output pixel, held while no valid pixel is presented.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_r <= '0;
        end else if (v2) begin
            pixel_r <= edge2 ? 8'hFF : 8'h00;
        end
    end
`else
    mag_t mag2;
    logic unused_threshold;

    assign unused_threshold = ^threshold;

    // Stage 2 magnitude register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mag2 <= '0;
        end else begin
            mag2 <= mag_sum;
        end
    end

    // Stage 3 saturates the magnitude to 8 bits, holding while no valid pixel is presented.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_r <= '0;
        end else if (v2) begin
            pixel_r <= (mag2 > mag_t'(255)) ? 8'hFF : mag2[7:0];
        end
    end
`endif

    // Stage 3 valid, tags and the frame completion pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r    <= 1'b0;
            sol_r      <= 1'b0;
            eol_r      <= 1'b0;
            eof_r      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_r    <= v2;
            sol_r      <= sol2;
            eol_r      <= eol2;
            eof_r      <= eof2;
            frame_done <= eof2;
        end
    end

    assign win.pixel_out = pixel_r;
    assign win.valid_out = valid_r;
    assign win.sol       = sol_r;
    assign win.eol       = eol_r;
    assign win.eof       = eof_r;

endmodule

// File: tb/tb_sobel_window_engine.sv
// Directed self-checking bench for sobel_window_engine.
// Optional feature macro: SOBEL_THRESHOLD_EN (expected pixels follow the build).
module tb_sobel_window_engine;
    import sobel_pkg::*;

    logic clk;
    logic reset_n;
    logic enable;
    dim_t image_width;
    dim_t image_height;
    pix_t threshold;
    logic frame_done;
    logic busy;
    logic drop_err;
    logic cfg_err;

    sobel_window_engine_if bus ();

    sobel_window_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .image_width  (image_width),
        .image_height (image_height),
        .threshold    (threshold),
        .win          (bus),
        .frame_done   (frame_done),
        .busy         (busy),
        .drop_err     (drop_err),
        .cfg_err      (cfg_err)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic       sol;
        logic       eol;
        logic       eof;
        logic       fd;
        int         cyc;
    } out_t;

    out_t outs[$];
    int   cyc      = 0;
    int   fd_count = 0;
    int   checks   = 0;
    int   errors   = 0;

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every presented pixel on the falling edge.
    always @(negedge clk) begin
        if (bus.valid_out) begin
            outs.push_back('{pix: bus.pixel_out, sol: bus.sol, eol: bus.eol,
                             eof: bus.eof, fd: frame_done, cyc: cyc});
        end
        if (frame_done) fd_count <= fd_count + 1;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [71:0] window, input logic valid);
        bus.window_in = window;
        bus.valid_in  = valid;
        step();
        bus.valid_in  = 1'b0;
    endtask

    task automatic resetDut();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic startFrame(input dim_t w, input dim_t h);
        image_width  = w;
        image_height = h;
        enable       = 1'b1;
        step();
        enable       = 1'b0;
    endtask

    function automatic logic [71:0] colWin(input logic [7:0] left, input logic [7:0] center, input logic [7:0] right);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = (k / 3 == 0) ? left : ((k / 3 == 1) ? center : right);
        end
        return w;
    endfunction

    function automatic logic [71:0] rowWin(input logic [7:0] top, input logic [7:0] mid, input logic [7:0] bot);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = (k % 3 == 0) ? top : ((k % 3 == 1) ? mid : bot);
        end
        return w;
    endfunction

    logic [71:0] grad_wins[3];
    logic [7:0]  exp_a[3];
    logic [7:0]  exp_b[3];

    initial begin
        int in_cyc;
        int fd_before;
        logic seen;

        reset_n       = 1'b0;
        enable        = 1'b0;
        image_width   = '0;
        image_height  = '0;
        threshold     = 8'd30;
        bus.window_in = '0;
        bus.valid_in  = 1'b0;

        grad_wins[0] = colWin(8'h00, 8'h40, 8'hFF);
        grad_wins[1] = rowWin(8'd10, 8'd15, 8'd20);
        grad_wins[2] = 72'h30;
`ifdef SOBEL_THRESHOLD_EN
        exp_a[0] = 8'hFF; exp_a[1] = 8'hFF; exp_a[2] = 8'hFF;
        exp_b[0] = 8'hFF; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
`else
        exp_a[0] = 8'hFF; exp_a[1] = 8'h28; exp_a[2] = 8'h60;
        exp_b[0] = 8'hFF; exp_b[1] = 8'h28; exp_b[2] = 8'h60;
`endif

        // Reset state.
        resetDut();
        checkOutput("rst_valid_out", bus.valid_out, 0);
        checkOutput("rst_pixel_out", bus.pixel_out, 0);
        checkOutput("rst_tags", {bus.sol, bus.eol, bus.eof}, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_errs", {drop_err, cfg_err}, 0);

        // Flat window frame, W=3 H=1.
        $display("[TB] flat frame");
        outs.delete();
        startFrame(11'd3, 11'd1);
        checkOutput("flat_busy", busy, 1);
        in_cyc = cyc;
        for (int i = 0; i < 3; i++) applyStimulus({9{8'h80}}, 1'b1);
        for (int i = 0; i < 6; i++) step();
        checkOutput("flat_count", outs.size(), 3);
        if (outs.size() == 3) begin
            checkOutput("flat_latency", outs[0].cyc - in_cyc, 3);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("flat_pix%0d", i), outs[i].pix, 0);
                checkOutput($sformatf("flat_tags%0d", i), {outs[i].sol, outs[i].eol, outs[i].eof, outs[i].fd},
                            (i == 0) ? 4'b1000 : ((i == 2) ? 4'b0111 : 4'b0000));
            end
        end
        checkOutput("flat_busy_end", busy, 0);
        checkOutput("flat_drop", drop_err, 0);

        // Gradient frames with two thresholds.
        $display("[TB] gradient frames");
        for (int f = 0; f < 2; f++) begin
            outs.delete();
            threshold = (f == 0) ? 8'd30 : 8'd50;
            startFrame(11'd3, 11'd1);
            for (int i = 0; i < 3; i++) applyStimulus(grad_wins[i], 1'b1);
            for (int i = 0; i < 6; i++) step();
            checkOutput($sformatf("grad%0d_count", f), outs.size(), 3);
            if (outs.size() == 3) begin
                for (int i = 0; i < 3; i++) begin
                    checkOutput($sformatf("grad%0d_pix%0d", f, i), outs[i].pix,
                                (f == 0) ? exp_a[i] : exp_b[i]);
                end
            end
        end
        checkOutput("hold_pixel", bus.pixel_out, exp_b[2]);
        checkOutput("idle_tags", {bus.valid_out, bus.sol, bus.eol, bus.eof}, 0);

        // W=4 H=3 back-to-back frame, followed by a stray window.
        $display("[TB] 4x3 frame");
        outs.delete();
        startFrame(11'd4, 11'd3);
        for (int i = 0; i < 12; i++) applyStimulus({9{8'h55}}, 1'b1);
        checkOutput("drain_drop_before", drop_err, 0);
        applyStimulus({9{8'h55}}, 1'b1);
        checkOutput("drain_drop_after", drop_err, 1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (frame_done) seen = 1'b1;
            else step();
        end
        checkOutput("fd_seen", seen, 1);
        checkOutput("busy_at_fd", busy, 1);
        step();
        checkOutput("busy_after_fd", busy, 0);
        checkOutput("fd_pulse", frame_done, 0);
        step();
        checkOutput("f43_count", outs.size(), 12);
        if (outs.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                checkOutput($sformatf("f43_tags%0d", i), {outs[i].sol, outs[i].eol, outs[i].eof, outs[i].fd},
                            {(i % 4 == 0), (i % 4 == 3), (i == 11), (i == 11)});
            end
        end

        // Mid-frame reset.
        $display("[TB] mid-frame reset");
        resetDut();
        checkOutput("rst_clears_drop", drop_err, 0);
        outs.delete();
        startFrame(11'd4, 11'd3);
        for (int i = 0; i < 5; i++) applyStimulus({9{8'h20}}, 1'b1);
        reset_n = 1'b0;
        step();
        checkOutput("mid_rst_valid", bus.valid_out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        fd_before = fd_count;
        outs.delete();
        for (int i = 0; i < 5; i++) step();
        checkOutput("mid_rst_flushed", outs.size(), 0);
        checkOutput("mid_rst_no_fd", fd_count, fd_before);
        startFrame(11'd4, 11'd3);
        applyStimulus({9{8'h20}}, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checkOutput("restart_count", outs.size(), 1);
        if (outs.size() == 1) begin
            checkOutput("restart_tags", {outs[0].sol, outs[0].eol, outs[0].eof}, 3'b100);
        end

        // Illegal and boundary dimensions.
        $display("[TB] configuration checks");
        resetDut();
        startFrame(11'd0, 11'd3);
        checkOutput("cfg_zero_err", cfg_err, 1);
        checkOutput("cfg_zero_busy", busy, 0);
        applyStimulus({9{8'h10}}, 1'b1);
        checkOutput("cfg_zero_drop", drop_err, 1);
        checkOutput("cfg_zero_idle", busy, 0);
        resetDut();
        startFrame(11'd4, 11'd1081);
        checkOutput("cfg_tall_err", cfg_err, 1);
        checkOutput("cfg_tall_busy", busy, 0);
        resetDut();
        startFrame(11'd1920, 11'd1080);
        checkOutput("cfg_max_err", cfg_err, 0);
        checkOutput("cfg_max_busy", busy, 1);
        resetDut();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
